// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 memory responder and its RAM.
// Also holds the address range check that the responder applies to every access.
package mips32_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } port_e;

    // A word address is backed by the array only if no bit at or above addr_w is set.
    function automatic logic addr_in_range(input logic [WORD_W-1:0] addr, input int addr_w);
        return (addr >> addr_w) == '0;
    endfunction

endpackage

// File: rtl/mips32_sram_sp.sv
// Single-port synchronous word RAM with a one-cycle registered read.
// The array has no reset and keeps its contents across a responder reset.
module mips32_sram_sp
    import mips32_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips32_mem_responder.sv
// Serves the core's fetch and data ports from one single-port RAM.
// Round-robin arbitration, programmable wait states and a one-cycle ack.
module mips32_mem_responder
    import mips32_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_ack,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [WORD_W-1:0] d_rdata,
    output logic              err,
    output logic              busy
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_e            state_q, state_d;
    port_e             port_q, port_d;
    port_e             last_grant_q, last_grant_d;
    port_e             grant_port;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              grant_valid;
    logic [WORD_W-1:0] req_addr, req_wdata;
    logic              req_we;
    logic              mem_issue, mem_en, mem_we;
    logic [WORD_W-1:0] mem_addr, mem_rdata;
    logic              resp_err;

    always_comb begin
        grant_valid = if_req | d_req;
        grant_port  = FETCH;
        if (if_req && d_req) begin
            grant_port = (last_grant_q == FETCH) ? DATA : FETCH;
        end else if (d_req) begin
            grant_port = DATA;
        end
        req_addr  = (grant_port == DATA) ? d_addr : if_addr;
        req_we    = (grant_port == DATA) && d_we;
        req_wdata = (grant_port == DATA) ? d_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            port_q       <= FETCH;
            last_grant_q <= FETCH;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    port_d  = grant_port;
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                last_grant_d = port_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // With no wait states the access leaves IDLE directly, so it must use the live request.
    always_comb begin
        mem_addr  = (state_q == IDLE) ? req_addr : addr_q;
        mem_we    = (state_q == IDLE) ? req_we : we_q;
        mem_issue = 1'b0;
        if (state_q == IDLE && grant_valid && WAIT_CYCLES == 0) begin
            mem_issue = 1'b1;
        end
        if (state_q == WAIT && cnt_q <= 4'd1) begin
            mem_issue = 1'b1;
        end
        mem_en = mem_issue && !rst && addr_in_range(mem_addr, ADDR_W);
    end

    mips32_sram_sp #(
        .ADDR_W(ADDR_W)
    ) u_sram (
        .clk  (clk),
        .en   (mem_en),
        .we   (mem_we),
        .addr (mem_addr[ADDR_W-1:0]),
        .wdata(mem_we ? ((state_q == IDLE) ? req_wdata : wdata_q) : '0),
        .rdata(mem_rdata)
    );

    always_comb begin
        if_ack   = 1'b0;
        d_ack    = 1'b0;
        if_rdata = '0;
        d_rdata  = '0;
        err      = 1'b0;
        busy     = (state_q != IDLE);
        resp_err = !addr_in_range(addr_q, ADDR_W);
        if (state_q == RESP) begin
            err = resp_err;
            if (port_q == FETCH) begin
                if_ack   = 1'b1;
                if_rdata = resp_err ? '0 : mem_rdata;
            end else begin
                d_ack   = 1'b1;
                d_rdata = (resp_err || we_q) ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Bench for mips32_mem_responder: three lanes with 1, 3 and 0 wait states,
// a per-cycle transaction-level model, plus directed literal expectations.
module tb_mips32_mem_responder;
    import mips32_pkg::*;

    localparam int NL = 3;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [NL];
    logic        if_req   [NL];
    logic [31:0] if_addr  [NL];
    logic        if_ack   [NL];
    logic [31:0] if_rdata [NL];
    logic        d_req    [NL];
    logic        d_we     [NL];
    logic [31:0] d_addr   [NL];
    logic [31:0] d_wdata  [NL];
    logic        d_ack    [NL];
    logic [31:0] d_rdata  [NL];
    logic        err      [NL];
    logic        busy     [NL];

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        mips32_mem_responder #(
            .ADDR_W     (AW),
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 3 : 0))
        ) u_dut (
            .clk     (clk),
            .rst     (rst[g]),
            .if_req  (if_req[g]),
            .if_addr (if_addr[g]),
            .if_ack  (if_ack[g]),
            .if_rdata(if_rdata[g]),
            .d_req   (d_req[g]),
            .d_we    (d_we[g]),
            .d_addr  (d_addr[g]),
            .d_wdata (d_wdata[g]),
            .d_ack   (d_ack[g]),
            .d_rdata (d_rdata[g]),
            .err     (err[g]),
            .busy    (busy[g])
        );
    end

    function automatic int lane_wait(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Model: one outstanding transaction per lane, counted down to its ack cycle.
    bit          m_pend  [NL];
    port_e       m_port  [NL];
    port_e       m_last  [NL];
    bit          m_we    [NL];
    logic [31:0] m_addr  [NL];
    logic [31:0] m_wdata [NL];
    int          m_left  [NL];
    logic [31:0] mmem    [NL][1024];

    always @(negedge clk) begin : model_compare
        logic        e_ia, e_da, e_err;
        logic [31:0] e_ird, e_drd, rd;
        bit          inr;
        port_e       p;
        for (int k = 0; k < NL; k++) begin
            e_ia = 0; e_da = 0; e_err = 0; e_ird = '0; e_drd = '0;
            if (m_pend[k] && m_left[k] == 0) begin
                inr   = (m_addr[k] >> AW) == 0;
                e_err = !inr;
                rd    = (!inr || m_we[k]) ? 32'd0 : mmem[k][m_addr[k][9:0]];
                if (m_port[k] == FETCH) begin
                    e_ia = 1; e_ird = rd;
                end else begin
                    e_da = 1; e_drd = rd;
                end
                if (inr && m_we[k]) mmem[k][m_addr[k][9:0]] = m_wdata[k];
            end
            checkOutput($sformatf("lane%0d if_ack @%0d", k, cyc), {31'd0, if_ack[k]}, {31'd0, e_ia});
            checkOutput($sformatf("lane%0d d_ack @%0d", k, cyc), {31'd0, d_ack[k]}, {31'd0, e_da});
            checkOutput($sformatf("lane%0d if_rdata @%0d", k, cyc), if_rdata[k], e_ird);
            checkOutput($sformatf("lane%0d d_rdata @%0d", k, cyc), d_rdata[k], e_drd);
            checkOutput($sformatf("lane%0d err @%0d", k, cyc), {31'd0, err[k]}, {31'd0, e_err});
            checkOutput($sformatf("lane%0d busy @%0d", k, cyc), {31'd0, busy[k]}, {31'd0, m_pend[k]});
            if (rst[k]) begin
                m_pend[k] = 0;
                m_last[k] = FETCH;
            end else if (m_pend[k]) begin
                if (m_left[k] == 0) begin
                    m_pend[k] = 0;
                    m_last[k] = m_port[k];
                end else begin
                    m_left[k]--;
                end
            end else if (if_req[k] || d_req[k]) begin
                if (if_req[k] && d_req[k]) p = (m_last[k] == FETCH) ? DATA : FETCH;
                else                       p = d_req[k] ? DATA : FETCH;
                m_pend[k]  = 1;
                m_port[k]  = p;
                m_addr[k]  = (p == DATA) ? d_addr[k] : if_addr[k];
                m_we[k]    = (p == DATA) && d_we[k];
                m_wdata[k] = d_wdata[k];
                m_left[k]  = lane_wait(k);
            end
        end
    end

    // One complete request/ack handshake; latency counted from the request's IDLE cycle.
    task automatic applyStimulus(input int k, input port_e p, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output logic e, output int lat);
        int start;
        bit got;
        @(posedge clk); #1;
        if (p == DATA) begin
            d_req[k] = 1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
        end else begin
            if_req[k] = 1; if_addr[k] = addr;
        end
        start = cyc; got = 0; rdata = '0; e = 0; lat = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((p == DATA) ? d_ack[k] : if_ack[k]) begin
                got   = 1;
                rdata = (p == DATA) ? d_rdata[k] : if_rdata[k];
                e     = err[k];
                lat   = cyc - start;
            end
        end
        if (!got) checkOutput($sformatf("lane%0d ack timeout", k), 32'd0, 32'd1);
        @(posedge clk); #1;
        d_req[k] = 0; if_req[k] = 0; d_we[k] = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] rd;
        logic        e;
        int          lat, n, acks, start;
        port_e       ports [4];
        logic [31:0] datas [4];
        int          acyc  [3];
        logic [31:0] exp_d [4];

        for (int k = 0; k < NL; k++) begin
            rst[k] = 1; if_req[k] = 0; if_addr[k] = '0; d_req[k] = 0; d_we[k] = 0;
            d_addr[k] = '0; d_wdata[k] = '0; m_pend[k] = 0; m_last[k] = FETCH; m_left[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) rst[k] = 0;

        $display("[TB] idle after reset");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle flags lane0", {28'd0, if_ack[0], d_ack[0], err[0], busy[0]}, 32'd0);
            checkOutput("idle rdata lane0", if_rdata[0] | d_rdata[0], 32'd0);
        end

        $display("[TB] store then load, 1 wait state");
        applyStimulus(0, DATA, 1, 32'd5, 32'hDEADBEEF, rd, e, lat);
        checkOutput("store latency", 32'(lat), 32'd2);
        checkOutput("store rdata", rd, 32'd0);
        applyStimulus(0, DATA, 0, 32'd5, 32'd0, rd, e, lat);
        checkOutput("load addr5", rd, 32'hDEADBEEF);

        $display("[TB] address range boundaries");
        applyStimulus(0, DATA, 1, 32'd1023, 32'hA5A50FF0, rd, e, lat);
        applyStimulus(0, DATA, 1, 32'd0, 32'd0, rd, e, lat);
        applyStimulus(0, DATA, 1, 32'd1024, 32'hFFFF0000, rd, e, lat);
        checkOutput("oor store err", {31'd0, e}, 32'd1);
        checkOutput("oor store rdata", rd, 32'd0);
        applyStimulus(0, DATA, 0, 32'd0, 32'd0, rd, e, lat);
        checkOutput("addr0 unchanged", rd, 32'd0);
        checkOutput("addr0 err", {31'd0, e}, 32'd0);
        applyStimulus(0, DATA, 0, 32'd1024, 32'd0, rd, e, lat);
        checkOutput("oor load rdata", rd, 32'd0);
        checkOutput("oor load err", {31'd0, e}, 32'd1);
        applyStimulus(0, DATA, 0, 32'd1023, 32'd0, rd, e, lat);
        checkOutput("load addr1023", rd, 32'hA5A50FF0);

        $display("[TB] request dropped mid-transaction");
        @(posedge clk); #1;
        d_req[0] = 1; d_we[0] = 1; d_addr[0] = 32'd11; d_wdata[0] = 32'h0BADF00D;
        start = cyc;
        @(posedge clk); #1;
        d_req[0] = 0; d_we[0] = 0;
        lat = -1;
        for (int i = 0; i < 10 && lat < 0; i++) begin
            @(negedge clk);
            if (d_ack[0]) lat = cyc - start;
        end
        checkOutput("dropped req ack latency", 32'(lat), 32'd2);
        applyStimulus(0, DATA, 0, 32'd11, 32'd0, rd, e, lat);
        checkOutput("dropped req store commits", rd, 32'h0BADF00D);

        $display("[TB] reset in response cycle");
        @(posedge clk); #1;
        d_req[0] = 1; d_we[0] = 1; d_addr[0] = 32'd9; d_wdata[0] = 32'h00000099;
        @(posedge clk);
        @(posedge clk); #1;
        rst[0] = 1; d_req[0] = 0; d_we[0] = 0;
        @(negedge clk);
        checkOutput("ack during reset RESP", {31'd0, d_ack[0]}, 32'd1);
        @(posedge clk); #1;
        rst[0] = 0;
        applyStimulus(0, DATA, 0, 32'd9, 32'd0, rd, e, lat);
        checkOutput("store before RESP reset", rd, 32'h00000099);

        $display("[TB] contention round-robin");
        applyStimulus(0, DATA, 1, 32'd3, 32'h28010078, rd, e, lat);
        @(posedge clk); #1;
        rst[0] = 1;
        @(posedge clk); #1;
        rst[0] = 0;
        @(posedge clk); #1;
        if_req[0] = 1; if_addr[0] = 32'd3; d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'd5;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (if_ack[0]) begin
                ports[n] = FETCH; datas[n] = if_rdata[0]; n++;
            end else if (d_ack[0]) begin
                ports[n] = DATA; datas[n] = d_rdata[0]; n++;
            end
        end
        @(posedge clk); #1;
        if_req[0] = 0; d_req[0] = 0;
        checkOutput("contention ack count", 32'(n), 32'd4);
        exp_d = '{32'hDEADBEEF, 32'h28010078, 32'hDEADBEEF, 32'h28010078};
        for (int i = 0; i < 4 && i < n; i++) begin
            checkOutput($sformatf("contention grant %0d", i), 32'(ports[i]),
                        (i % 2 == 0) ? 32'(DATA) : 32'(FETCH));
            checkOutput($sformatf("contention data %0d", i), datas[i], exp_d[i]);
        end

        $display("[TB] reset during wait, 3 wait states");
        applyStimulus(1, DATA, 1, 32'd7, 32'h11112222, rd, e, lat);
        checkOutput("lane1 store latency", 32'(lat), 32'd4);
        @(posedge clk); #1;
        d_req[1] = 1; d_we[1] = 1; d_addr[1] = 32'd7; d_wdata[1] = 32'hBAD00007;
        @(posedge clk);
        @(posedge clk); #1;
        rst[1] = 1; d_req[1] = 0; d_we[1] = 0;
        acks = 0;
        @(negedge clk);
        if (d_ack[1]) acks++;
        @(posedge clk); #1;
        rst[1] = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (d_ack[1]) acks++;
        end
        checkOutput("no ack after WAIT reset", 32'(acks), 32'd0);
        applyStimulus(1, DATA, 0, 32'd7, 32'd0, rd, e, lat);
        checkOutput("old value after WAIT reset", rd, 32'h11112222);

        $display("[TB] zero wait states, back-to-back fetches");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2, DATA, 1, 32'(i), 32'h10000000 + 32'(i), rd, e, lat);
            if (i == 0) checkOutput("lane2 store latency", 32'(lat), 32'd1);
        end
        @(posedge clk); #1;
        if_req[2] = 1; if_addr[2] = 32'd0;
        start = cyc;
        for (int i = 0; i < 3; i++) begin
            acyc[i] = -100;
            for (int j = 0; j < 10 && acyc[i] < 0; j++) begin
                @(negedge clk);
                if (if_ack[2]) begin
                    acyc[i] = cyc;
                    checkOutput($sformatf("b2b fetch data %0d", i), if_rdata[2], 32'h10000000 + 32'(i));
                end
            end
            @(posedge clk); #1;
            if (i < 2) if_addr[2] = 32'(i + 1);
            else       if_req[2] = 0;
        end
        checkOutput("b2b first latency", 32'(acyc[0] - start), 32'd1);
        checkOutput("b2b spacing 1", 32'(acyc[1] - acyc[0]), 32'd2);
        checkOutput("b2b spacing 2", 32'(acyc[2] - acyc[1]), 32'd2);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips32_mem_responder.md
# mips32_mem_responder

Memory-side responder for the MIPS32 core's instruction-fetch and data (LW/SW) accesses. It serves two requester ports from one single-ported word-addressed array of 32-bit words. The block arbitrates between the two ports, inserts a programmable number of wait states, and signals completion with a one-cycle acknowledge. It sits between the pipelined core and its program/data store, replacing the core-internal memory array.

## Interface
Parameters:
- `ADDR_W`, 10: array depth is 2**ADDR_W words.
- `WAIT_CYCLES`, 1: wait states per access, 0..15.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request, level; held until `if_ack`.
- `if_addr`  in  32  fetch word address.
- `if_ack`  out  1  one-cycle fetch completion.
- `if_rdata`  out  32  fetched word; valid while `if_ack`=1.
- `d_req`  in  1  data request, level; held until `d_ack`.
- `d_we`  in  1  1 = store (SW), 0 = load (LW).
- `d_addr`  in  32  data word address.
- `d_wdata`  in  32  store data.
- `d_ack`  out  1  one-cycle data completion.
- `d_rdata`  out  32  load data; valid while `d_ack`=1; 0 for stores.
- `err`  out  1  pulses with the ack when the address is out of range.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant that port.
  - If both are high, grant the port not granted last (round-robin). `last_grant` resets to FETCH, so the first contention grants DATA.
  - On grant, latch port id, address, `we` and `wdata`, and load the wait counter with WAIT_CYCLES.
  - Next state is WAIT, or RESP when WAIT_CYCLES=0.
- WAIT: decrement the counter. When it reaches 0, perform the array access and go to RESP.
- Access rules:
  - Address is in range when `addr[31:ADDR_W]`==0.
  - In-range read: rdata = array[addr].
  - In-range write: array[addr] <= wdata.
  - Out of range: the write is suppressed, rdata = 0, and `err` is set.
- RESP:
  - Assert the granted port's ack (and `err` if set) for exactly one cycle.
  - Drive that port's rdata.
  - Update `last_grant`, then return to IDLE.
- The other port's ack and rdata stay 0.
- A requester that drops `req` mid-transaction does not abort it. The access still completes, a store still commits, and the ack still pulses.
- The array is not cleared by reset.

## Timing
- Reset values: `if_ack`=0, `d_ack`=0, `if_rdata`=0, `d_rdata`=0, `err`=0, `busy`=0, state=IDLE, counter=0, `last_grant`=FETCH.
- Latency: a request granted at IDLE edge E produces its ack in the cycle starting at edge E+WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- The transfer completes on the edge where ack=1. The requester updates `req` on that edge.
- Back-to-back requests are accepted in the IDLE cycle that follows RESP.
- A store is visible to any access granted after its ack.
- Reset asserted in WAIT: the access is dropped, no write commits, and no ack is produced.
- Reset asserted in the RESP cycle: the outputs clear on that edge. The write has already committed.
- Address 0 and address 2**ADDR_W-1 are valid. Address 2**ADDR_W is out of range.

## Structure
- Shared package `mips32_pkg` holds:
  - the state enum (IDLE/WAIT/RESP);
  - the port-id constants FETCH/DATA;
  - the word width constant 32.
- Sub-module `mips32_sram_sp`: a single-port synchronous word RAM with inputs `en`, `we`, `addr`, `wdata` and output `rdata`, with 1-cycle read.
  - The FSM issues the access on the edge leaving WAIT, or leaving IDLE when WAIT_CYCLES=0.
  - The FSM captures `rdata` in RESP.

## Test plan
- Reset, then idle with no requests: all outputs stay 0 and `busy`=0 for 20 cycles.
- Single store then load, with WAIT_CYCLES=1:
  - Store `d_we`=1, `d_addr`=5, `d_wdata`=32'hDEADBEEF. Required response: `d_ack` exactly 2 cycles after grant and `d_rdata`=0.
  - Then load `d_addr`=5. Required response: `d_rdata`=32'hDEADBEEF.
- Contention with both requests held high for 4 transactions:
  - Grants go DATA, FETCH, DATA, FETCH.
  - `if_rdata` matches a preloaded array[`if_addr`=3]=32'h28010078.
- Out-of-range access:
  - Store to `d_addr`=1024 (ADDR_W=10): `err`=1 with `d_ack`, and the array is unchanged at 0.
  - Load from address 1024: `d_rdata`=0 and `err`=1.
- Reset during WAIT with WAIT_CYCLES=3:
  - Store to address 7, and assert `rst` in the 2nd wait cycle.
  - Required response: no `d_ack`, and a later load from address 7 returns the old value.
- WAIT_CYCLES=0 with back-to-back fetches at addresses 0,1,2: an ack arrives every 2 cycles with the correct data.
